// File: rtl/full_slt32_pkg.sv
// full_slt32_pkg: shared ALU word type, width and opcode constants.
package full_slt32_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_t;
  localparam alu_op_t ALU_OP_SLT = ALU_SLT;
endpackage

// File: rtl/full_slt32_slice.sv
// slt_bit_slice: one-bit full adder on (a_i, ~b_i, cin) for the subtract chain.
module slt_bit_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic cin,
  output logic sum_i,
  output logic cout
);
  logic nb;
  assign nb = ~b_i;
  assign sum_i = a_i ^ nb ^ cin;
  assign cout = (a_i & nb) | (cin & (a_i ^ nb));
endmodule

// File: rtl/full_slt32.sv
// full_slt32: registered signed a<b via ripple a+~b+1 with overflow correction.
module full_slt32
  import full_slt32_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  word_t a,
  input  word_t b,
  output word_t slt
);
  word_t d;
  logic [WORD_W:0] c;
  logic v, lt;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WORD_W; i++) begin : g_slice
    slt_bit_slice u_slice (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .cin  (c[i]),
      .sum_i(d[i]),
      .cout (c[i+1])
    );
  end
  // only the sign bit of the difference feeds the compare
  logic unused_d;
  assign unused_d = ^d[WORD_W-2:0];
  assign v = c[WORD_W-1] ^ c[WORD_W];
  assign lt = d[WORD_W-1] ^ v;
  always_ff @(posedge clk)
    slt <= reset ? '0 : {{(WORD_W-1){1'b0}}, lt};
endmodule

// File: tb/tb_full_slt32.sv
// tb_full_slt32: directed and random checks of full_slt32 against a signed-compare model.
module tb_full_slt32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] slt;
  int total = 0;
  int bad = 0;
  full_slt32 dut (.clk(clk), .reset(reset), .a(a), .b(b), .slt(slt));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, slt, exp);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] x, y;
    reset = 1'b1;
    a = 32'h0;
    b = 32'h1;
    @(posedge clk);
    #1 check("reset_c1", slt, 32'h0);
    @(posedge clk);
    #1 check("reset_c2", slt, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1 check("reset_release", slt, 32'h1);
    step("mixed_neg_a1", 32'h8000_0100, 32'h0208_2100, 32'h1);
    step("mixed_neg_a2", 32'hFFC1_FE0F, 32'h0230_3003, 32'h1);
    step("mixed_pos_a", 32'h0230_3003, 32'hFFC1_FE0F, 32'h0);
    step("equal_neg", 32'h8208_2100, 32'h8208_2100, 32'h0);
    step("same_sign_neg", 32'h8208_2100, 32'h8000_0000, 32'h0);
    step("ovf_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
    step("ovf_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
    step("neg1_vs_0", 32'hFFFF_FFFF, 32'h0000_0000, 32'h1);
    step("zero_vs_neg1", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0);
    step("pos_lt", 32'h0000_0005, 32'h0000_0006, 32'h1);
    a = 32'h8000_0000;
    b = 32'h0000_0001;
    reset = 1'b1;
    @(posedge clk);
    #1 check("midstream_reset", slt, 32'h0);
    reset = 1'b0;
    step("after_midstream", 32'h8000_0000, 32'h0000_0001, 32'h1);
    for (int i = 0; i < 10000; i++) begin
      x = pick();
      y = pick();
      step("random", x, y, model(x, y));
      check("upper_zero", {1'b0, slt[31:1]}, 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
